// File: rtl/fpga_spi_cfg_host.sv
// fpga_spi_cfg_host: SPI mode-0 host streaming bitstream bytes into an FPGA config slave,
// returning miso bytes and reporting done once the FPGA's config_busy drops.
module fpga_spi_cfg_host #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    input  logic       miso_i,
    input  logic       config_busy_i,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, WAIT_CFG} state_t;

    localparam logic [15:0] DIV_T   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_T = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_T  = 16'(CS_HOLD - 1);

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [3:0]  r_tog;
    logic [7:0]  r_tx, r_rx;
    logic        r_last;
    logic        w_accept, w_tick, w_byte_end;

    assign s_ready_o  = (r_state == IDLE) || (r_state == NEXT);
    assign w_accept   = s_valid_i && s_ready_o;
    assign w_tick     = (r_state == SHIFT) && (r_cnt == DIV_T);
    assign w_byte_end = w_tick && (r_tog == 4'd15);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_accept ? SETUP : IDLE;
            SETUP:    w_next = (r_cnt == SETUP_T) ? SHIFT : SETUP;
            SHIFT:    w_next = w_byte_end ? (r_last ? HOLD : NEXT) : SHIFT;
            NEXT:     w_next = w_accept ? SHIFT : NEXT;
            HOLD:     w_next = (r_cnt == HOLD_T) ? WAIT_CFG : HOLD;
            WAIT_CFG: w_next = config_busy_i ? WAIT_CFG : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_tog      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_last     <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            sclk_o     <= 1'b0;
            cs_n_o     <= 1'b1;
            mosi_o     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            done_o     <= 1'b0;
            // one counter serves the setup/hold timers and the sclk divider
            r_cnt      <= (w_next != r_state || w_tick) ? '0 : r_cnt + 16'd1;
            if (w_accept) begin
                r_tx   <= {s_data_i[6:0], 1'b0};
                mosi_o <= s_data_i[7];
                r_last <= s_last_i;
                cs_n_o <= 1'b0;
                busy_o <= 1'b1;
            end
            if (w_tick) begin
                sclk_o <= ~sclk_o;
                r_tog  <= r_tog + 4'd1;
                if (!sclk_o) begin
                    r_rx <= {r_rx[6:0], miso_i};
                end else if (r_tog != 4'd15) begin
                    mosi_o <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end else begin
                    rx_data_o  <= r_rx;
                    rx_valid_o <= 1'b1;
                end
            end
            if (r_state == HOLD && r_cnt == HOLD_T) begin
                cs_n_o <= 1'b1;
                mosi_o <= 1'b0;
            end
            if (r_state == WAIT_CFG && !config_busy_i) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpga_spi_cfg_host.sv
// tb_fpga_spi_cfg_host: randomized checks of the SPI config host against a byte-level model
// (loopback rx equals tx, MSB-first mosi, cs_n low time from frame arithmetic).
module tb_fpga_spi_cfg_host;
    localparam int CLK_DIV = 2, CS_SETUP = 2, CS_HOLD = 2;

    logic       clk = 1'b0, rst_i = 1'b1;
    logic [7:0] s_data_i = '0;
    logic       s_valid_i = 1'b0, s_last_i = 1'b0, config_busy_i = 1'b0;
    logic       s_ready_o, rx_valid_o, sclk_o, cs_n_o, mosi_o, miso_i, busy_o, done_o;
    logic [7:0] rx_data_o;

    logic [7:0] d1_s_data = '0;
    logic       d1_s_valid = 1'b0, d1_s_last = 1'b0;
    logic       d1_s_ready, d1_rx_valid, d1_sclk, d1_cs_n, d1_mosi, d1_busy, d1_done;
    logic [7:0] d1_rx_data;

    assign miso_i = mosi_o;
    always #5 clk = ~clk;

    fpga_spi_cfg_host #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
        .s_ready_o(s_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .sclk_o(sclk_o),
        .cs_n_o(cs_n_o), .mosi_o(mosi_o), .miso_i(miso_i), .config_busy_i(config_busy_i),
        .busy_o(busy_o), .done_o(done_o));

    fpga_spi_cfg_host #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .s_data_i(d1_s_data), .s_valid_i(d1_s_valid), .s_last_i(d1_s_last),
        .s_ready_o(d1_s_ready), .rx_data_o(d1_rx_data), .rx_valid_o(d1_rx_valid), .sclk_o(d1_sclk),
        .cs_n_o(d1_cs_n), .mosi_o(d1_mosi), .miso_i(1'b1), .config_busy_i(1'b0),
        .busy_o(d1_busy), .done_o(d1_done));

    int n_cmp = 0, n_err = 0, viol = 0, stall_bad = 0, cyc = 0;
    int cs_fall_cyc = 0, cs_low_len = 0, cs_rise_cyc = 0, cfg_low_cyc = 0, done_cyc = 0, done_cnt = 0;
    bit awaiting = 1'b0;
    logic prev_sclk = 1'b0, prev_cs = 1'b1;
    bit q_mosi[$];
    logic [7:0] q_rx[$];
    int q_rx_cyc[$];
    logic [7:0] tx_q[$];

    // bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!cs_n_o && prev_cs) cs_fall_cyc = cyc;
        if (cs_n_o && !prev_cs) begin
            cs_low_len = cyc - cs_fall_cyc;
            cs_rise_cyc = cyc;
            awaiting = 1'b1;
        end
        if (awaiting && !config_busy_i) begin
            cfg_low_cyc = cyc;
            awaiting = 1'b0;
        end
        if (sclk_o && !prev_sclk) q_mosi.push_back(mosi_o);
        if (rx_valid_o) begin
            q_rx.push_back(rx_data_o);
            q_rx_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if ((cs_n_o && sclk_o) || (!cs_n_o && !busy_o)) viol++;
        prev_sclk = sclk_o;
        prev_cs = cs_n_o;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        q_mosi.delete();
        q_rx.delete();
        q_rx_cyc.delete();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (s_ready_o) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic send_frame(input int stall_after, input int stall_len, output bit ok);
        bit r;
        ok = 1'b1;
        for (int i = 0; i < tx_q.size(); i++) begin
            s_data_i = tx_q[i];
            s_last_i = (i == tx_q.size() - 1);
            s_valid_i = 1'b1;
            wait_ready(r);
            if (!r) begin
                ok = 1'b0;
                s_valid_i = 1'b0;
                return;
            end
            tick();
            s_valid_i = 1'b0;
            s_last_i = 1'($urandom);
            s_data_i = 8'($urandom);
            if (i == stall_after && i != tx_q.size() - 1) begin
                wait_ready(r);
                if (!r) begin
                    ok = 1'b0;
                    return;
                end
                for (int k = 0; k < stall_len; k++) begin
                    if (sclk_o !== 1'b0 || cs_n_o !== 1'b0) stall_bad++;
                    tick();
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({s_ready_o, rx_data_o, rx_valid_o, sclk_o, cs_n_o, mosi_o, busy_o, done_o} !== 15'b1_00000000_0_0_1_0_0_0) begin
            n_err++;
            $display("FAIL reset_values: got %b required %b",
                {s_ready_o, rx_data_o, rx_valid_o, sclk_o, cs_n_o, mosi_o, busy_o, done_o}, 15'b1_00000000_0_0_1_0_0_0);
        end
        rst_i = 1'b0;
        viol = 0;
        tick();
    endtask

    task automatic test_single;
        bit ok1, ok2;
        int d0;
        logic [7:0] e = 8'hA5;
        clear_mon();
        tx_q = '{8'hA5};
        d0 = done_cnt;
        send_frame(-1, 0, ok1);
        wait_done(d0, ok2);
        repeat (3) tick();
        n_cmp++;
        if (!(ok1 && ok2)) begin n_err++; $display("FAIL single_timeout: got %0d%0d required 11", ok1, ok2); end
        n_cmp++;
        if (q_mosi.size() !== 8) begin n_err++; $display("FAIL single_mosi_count: got %0d required 8", q_mosi.size()); end
        for (int b = 0; b < 8; b++) begin
            n_cmp++;
            if (b >= q_mosi.size() || q_mosi[b] !== e[7-b]) begin
                n_err++;
                $display("FAIL single_mosi_bit%0d: required %0d", b, e[7-b]);
            end
        end
        n_cmp++;
        if (q_rx.size() !== 1 || q_rx[0] !== 8'hA5) begin n_err++; $display("FAIL single_rx: count %0d required 1 byte a5", q_rx.size()); end
        n_cmp++;
        if (cs_low_len !== 36) begin n_err++; $display("FAIL single_cs_low: got %0d required 36", cs_low_len); end
        n_cmp++;
        if (done_cyc - cs_rise_cyc !== 1) begin n_err++; $display("FAIL single_done_delay: got %0d required 1", done_cyc - cs_rise_cyc); end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL single_done_count: got %0d required 1", done_cnt - d0); end
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b required 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2;
        int d0;
        clear_mon();
        tx_q = '{8'h01, 8'h80, 8'hFF};
        d0 = done_cnt;
        send_frame(-1, 0, ok1);
        wait_done(d0, ok2);
        repeat (3) tick();
        n_cmp++;
        if (!(ok1 && ok2)) begin n_err++; $display("FAIL b2b_timeout: got %0d%0d required 11", ok1, ok2); end
        n_cmp++;
        if (q_rx.size() !== 3) begin n_err++; $display("FAIL b2b_rx_count: got %0d required 3", q_rx.size()); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (k >= q_rx.size() || q_rx[k] !== tx_q[k]) begin n_err++; $display("FAIL b2b_rx%0d: required %h", k, tx_q[k]); end
        end
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (k >= q_rx_cyc.size() || q_rx_cyc[k] - q_rx_cyc[k-1] !== 33) begin
                n_err++;
                $display("FAIL b2b_spacing%0d: required 33", k);
            end
        end
        n_cmp++;
        if (cs_low_len !== 102) begin n_err++; $display("FAIL b2b_cs_low: got %0d required 102", cs_low_len); end
    endtask

    task automatic test_stall;
        bit ok1, ok2;
        int d0;
        clear_mon();
        tx_q = '{8'($urandom), 8'($urandom)};
        stall_bad = 0;
        d0 = done_cnt;
        send_frame(0, 10, ok1);
        wait_done(d0, ok2);
        repeat (3) tick();
        n_cmp++;
        if (!(ok1 && ok2)) begin n_err++; $display("FAIL stall_timeout: got %0d%0d required 11", ok1, ok2); end
        n_cmp++;
        if (stall_bad !== 0) begin n_err++; $display("FAIL stall_lines: got %0d bad cycles required 0", stall_bad); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (k >= q_rx.size() || q_rx[k] !== tx_q[k]) begin n_err++; $display("FAIL stall_rx%0d: required %h", k, tx_q[k]); end
        end
        n_cmp++;
        if (cs_low_len !== CS_SETUP + 32*CLK_DIV + 11 + CS_HOLD) begin
            n_err++;
            $display("FAIL stall_cs_low: got %0d required %0d", cs_low_len, CS_SETUP + 32*CLK_DIV + 11 + CS_HOLD);
        end
    endtask

    task automatic test_abort;
        bit ok, ok2;
        int d0;
        clear_mon();
        s_data_i = 8'h3C;
        s_last_i = 1'b1;
        s_valid_i = 1'b1;
        wait_ready(ok);
        tick();
        s_valid_i = 1'b0;
        for (int k = 0; k < 200 && q_mosi.size() < 3; k++) tick();
        rst_i = 1'b1;
        tick();
        n_cmp++;
        if ({cs_n_o, sclk_o, s_ready_o} !== 3'b101) begin n_err++; $display("FAIL abort_lines: got %b required 101", {cs_n_o, sclk_o, s_ready_o}); end
        rst_i = 1'b0;
        d0 = done_cnt;
        repeat (60) tick();
        n_cmp++;
        if (q_rx.size() !== 0 || done_cnt !== d0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d rx %0d done required 0 0", q_rx.size(), done_cnt - d0);
        end
        clear_mon();
        tx_q = '{8'($urandom)};
        send_frame(-1, 0, ok);
        wait_done(d0, ok2);
        repeat (3) tick();
        n_cmp++;
        if (!(ok && ok2) || q_rx.size() !== 1 || q_rx[0] !== tx_q[0] || cs_low_len !== 36) begin
            n_err++;
            $display("FAIL abort_recover: rx count %0d cs_low %0d required 1 byte %h cs_low 36", q_rx.size(), cs_low_len, tx_q[0]);
        end
    endtask

    task automatic test_cfg_busy;
        bit ok1, ok2;
        int d0, bad = 0;
        clear_mon();
        config_busy_i = 1'b1;
        tx_q = '{8'($urandom)};
        d0 = done_cnt;
        send_frame(-1, 0, ok1);
        for (int k = 0; k < 200 && !cs_n_o; k++) tick();
        for (int k = 0; k < 20; k++) begin
            if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
            tick();
        end
        config_busy_i = 1'b0;
        wait_done(d0, ok2);
        repeat (30) tick();
        n_cmp++;
        if (!(ok1 && ok2)) begin n_err++; $display("FAIL cfg_timeout: got %0d%0d required 11", ok1, ok2); end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL cfg_busy_held: got %0d bad cycles required 0", bad); end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL cfg_done_count: got %0d required 1", done_cnt - d0); end
        n_cmp++;
        if (done_cyc !== cfg_low_cyc + 1) begin n_err++; $display("FAIL cfg_done_time: got %0d required %0d", done_cyc, cfg_low_cyc + 1); end
        n_cmp++;
        if (cfg_low_cyc - cs_rise_cyc !== 20) begin n_err++; $display("FAIL cfg_release_time: got %0d required 20", cfg_low_cyc - cs_rise_cyc); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int n, sa, sl, gaps, d0;
            bit ok1, ok2;
            logic [7:0] e;
            n = $urandom_range(1, 4);
            sa = $urandom_range(0, 3);
            sl = $urandom_range(0, 6);
            clear_mon();
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            gaps = (n - 1) + ((sa < n - 1) ? sl : 0);
            d0 = done_cnt;
            send_frame(sa, sl, ok1);
            wait_done(d0, ok2);
            repeat (3) tick();
            n_cmp++;
            if (!(ok1 && ok2)) begin n_err++; $display("FAIL rand%0d_timeout: got %0d%0d required 11", it, ok1, ok2); end
            n_cmp++;
            if (q_rx.size() !== n) begin n_err++; $display("FAIL rand%0d_rx_count: got %0d required %0d", it, q_rx.size(), n); end
            for (int k = 0; k < n; k++) begin
                n_cmp++;
                if (k >= q_rx.size() || q_rx[k] !== tx_q[k]) begin n_err++; $display("FAIL rand%0d_rx%0d: required %h", it, k, tx_q[k]); end
            end
            for (int b = 0; b < 8*n; b++) begin
                e = tx_q[b/8];
                n_cmp++;
                if (b >= q_mosi.size() || q_mosi[b] !== e[7 - b%8]) begin
                    n_err++;
                    $display("FAIL rand%0d_mosi%0d: required %0d", it, b, e[7 - b%8]);
                end
            end
            n_cmp++;
            if (cs_low_len !== CS_SETUP + 16*CLK_DIV*n + gaps + CS_HOLD) begin
                n_err++;
                $display("FAIL rand%0d_cs_low: got %0d required %0d", it, cs_low_len, CS_SETUP + 16*CLK_DIV*n + gaps + CS_HOLD);
            end
        end
    endtask

    task automatic test_div1;
        int rise_cyc[$];
        int mb = 0, nrx = 0;
        logic [7:0] rx = '0;
        logic ps = 1'b0;
        bit seen_done = 1'b0;
        d1_s_data = 8'h00;
        d1_s_last = 1'b1;
        d1_s_valid = 1'b1;
        for (int k = 0; k < 50 && !d1_s_ready; k++) tick();
        tick();
        d1_s_valid = 1'b0;
        d1_s_last = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (d1_sclk && !ps) rise_cyc.push_back(k);
            ps = d1_sclk;
            if (!d1_cs_n && d1_mosi !== 1'b0) mb++;
            if (d1_rx_valid) begin rx = d1_rx_data; nrx++; end
            if (d1_done) seen_done = 1'b1;
            tick();
        end
        n_cmp++;
        if (rise_cyc.size() !== 8) begin n_err++; $display("FAIL div1_rises: got %0d required 8", rise_cyc.size()); end
        for (int k = 1; k < 8; k++) begin
            n_cmp++;
            if (k >= rise_cyc.size() || rise_cyc[k] - rise_cyc[k-1] !== 2) begin n_err++; $display("FAIL div1_period%0d: required 2", k); end
        end
        n_cmp++;
        if (nrx !== 1 || rx !== 8'hFF) begin n_err++; $display("FAIL div1_rx: got %0d pulses %h required 1 pulse ff", nrx, rx); end
        n_cmp++;
        if (mb !== 0) begin n_err++; $display("FAIL div1_mosi: got %0d nonzero cycles required 0", mb); end
        n_cmp++;
        if (!seen_done) begin n_err++; $display("FAIL div1_done: got 0 required 1"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_abort();
        test_cfg_busy();
        test_random();
        test_div1();
        n_cmp++;
        if (viol !== 0) begin n_err++; $display("FAIL bus_invariants: got %0d bad cycles required 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
